regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file for the RV32 core family: generalises the 32x32, two-read / one-write register file to configurable width, depth and read-port count. It adds a synchronous reset that sequentially clears every entry through a small state machine, plus an optional same-cycle write-to-read bypass. It sits in decode, fed by instruction register fields and written from writeback.

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of registers (>= 2, need not be a power of two)
- NREAD, 2, number of combinational read ports (>= 1)
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- we3  in  1  write enable
- wa3  in  AW  write address
- wd3  in  XLEN  write data
- ra  in  NREAD x AW  read addresses, one per port
- rd  out  NREAD x XLEN  read data, one per port
- busy  out  1  high while the clear sequence runs
- wr_drop  out  1  one-cycle pulse: a write was discarded during clear

## Operation
- States: CLEAR and IDLE. The state register, clear counter `cnt` (AW bits) and `wr_drop` are all registered.
- rst high at an edge -> state=CLEAR, cnt=0, wr_drop=0. This holds regardless of current state; rst mid-clear restarts at cnt=0.
- CLEAR, rst low: entry[cnt] <= 0 each edge.
  - cnt==DEPTH-1 -> state=IDLE, cnt=0.
  - Otherwise cnt <= cnt+1.
- IDLE: write occurs at the edge when we3=1, wa3!=0 and wa3<DEPTH. Otherwise no entry changes.
- Entry 0 is hardwired zero. Writes to it are ignored silently (no wr_drop).
- Write in CLEAR with we3=1: discarded. wr_drop=1 in the following cycle, else 0. The clear value wins even if wa3==cnt.
- busy = (state==CLEAR), combinational from the state register.
- Read port i, combinational:
  - rd[i]=0 if busy, ra[i]==0, or ra[i]>=DEPTH.
  - Otherwise rd[i]=entry[ra[i]] (bypass rules in Configuration).
- All ports are independent. Any number may address the same entry.
- Widths: no arithmetic on data; address compares are AW-bit unsigned.

## Timing
- Reset values, after any edge with rst=1: busy=1, wr_drop=0, all rd=0.
- The clear sequence takes exactly DEPTH edges with rst low. busy falls after the DEPTH-th edge.
- First accepted write: the cycle in which busy is first low.
- Write latency: without bypass, the new value is visible on rd the cycle after the write edge.
- Read latency: 0 cycles (combinational).
- Entry contents before the first clear completes are don't-care; they are never visible because rd=0 while busy.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In IDLE, if we3=1, wa3!=0, wa3<DEPTH and ra[i]==wa3, then rd[i]=wd3 in the same cycle (write-through).
  - Applies per port.
  - No bypass in CLEAR.
- REGFILE_BYPASS_EN undefined: rd[i] returns the stored value, which is the pre-write value during the write cycle.

## Structure
- Package regfile_pkg holds:
  - default XLEN/DEPTH/NREAD constants
  - state enum typedef rf_state_t {RF_CLEAR, RF_IDLE}
  - ZERO_REG address constant (0)
- Sub-module regfile_clr_fsm:
  - contains the state register, cnt and wr_drop
  - outputs busy, clr_we and clr_addr
- Top level regfile_mp contains the storage array, write mux (clear vs normal) and read/bypass logic.

## Test plan
- Reset/clear: hold rst 2 cycles, release.
  - busy=1 for exactly 32 cycles (DEPTH=32), then 0.
  - Reading all 31 nonzero addresses then returns 0.
- Write/read: in IDLE write wa3=5, wd3=0xDEADBEEF.
  - Next cycle ra[0]=5 and ra[1]=5 both return 0xDEADBEEF.
  - Writing wa3=0, wd3=0x1234 leaves rd=0 for ra=0, with wr_drop=0.
- Drop during clear: we3=1, wa3=3, wd3=0xAA at clear cycle 3.
  - wr_drop=1 in the following cycle.
  - After clear, ra=3 reads 0.
- Reset mid-clear: assert rst at clear cycle 10 for 1 cycle. busy then stays high for 32 further cycles.
- Bypass: with REGFILE_BYPASS_EN, same-cycle we3=1, wa3=7, wd3=0x55, ra[1]=7.
  - rd[1]=0x55 that cycle.
  - Without the macro, rd[1] shows the old value (0) that cycle and 0x55 the next.
- Parameter sweep: DEPTH=24, NREAD=3, XLEN=64.
  - Clear lasts 24 cycles.
  - ra=30 returns 0; write to wa3=30 is ignored.
  - Full-width 64-bit data round-trips on all 3 ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and address-width helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned NREAD_DEF = 2;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;

  // Address width for a given depth; depth is always >= 2 so this is >= 1.
  function automatic int unsigned aw_of(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every entry after reset, then idles; flags writes dropped while clearing.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we3,
  output logic                       busy,
  output logic                       wr_drop,
  output logic                       clr_we,
  output logic [aw_of(DEPTH)-1:0]    clr_addr
);

  localparam int unsigned AW = aw_of(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     r_state;
  rf_state_t     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_wr_drop;
  logic          w_wr_drop_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RF_CLEAR;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wr_drop_nxt = 1'b0;
    if (r_state == RF_CLEAR) begin
      w_wr_drop_nxt = we3;
      if (r_cnt == LAST) begin
        w_state_nxt = RF_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + AW'(1);
      end
    end
  end

  assign busy     = (r_state == RF_CLEAR);
  assign clr_we   = busy & ~rst;
  assign clr_addr = r_cnt;
  assign wr_drop  = r_wr_drop;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with sequential clear after reset.
// Define REGFILE_BYPASS_EN for same-cycle write-through to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NREAD = NREAD_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 we3,
  input  logic [aw_of(DEPTH)-1:0]              wa3,
  input  logic [XLEN-1:0]                      wd3,
  input  logic [NREAD-1:0][aw_of(DEPTH)-1:0]   ra,
  output logic [NREAD-1:0][XLEN-1:0]           rd,
  output logic                                 busy,
  output logic                                 wr_drop
);

  localparam int unsigned   AW      = aw_of(DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);

  logic            w_busy;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_wr_en;
  logic [XLEN-1:0] r_mem [DEPTH];

  // Writable/readable addresses exclude the hardwired zero entry and anything past DEPTH.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != ZERO_A) && ({1'b0, a} < DEPTH_L);
  endfunction

  regfile_clr_fsm #(
    .DEPTH (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .we3      (we3),
    .busy     (w_busy),
    .wr_drop  (wr_drop),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign busy    = w_busy;
  assign w_wr_en = ~w_busy & ~rst & we3 & addr_ok(wa3);

  // Clear has priority; normal writes only reach the array in IDLE.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[wa3] <= wd3;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREAD); i++) begin
      rd[i] = '0;
      if (!w_busy && addr_ok(ra[i])) begin
`ifdef REGFILE_BYPASS_EN
        rd[i] = (w_wr_en && (ra[i] == wa3)) ? wd3 : r_mem[ra[i]];
`else
        rd[i] = r_mem[ra[i]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32x2 instance plus a 24x64x3 parameter sweep instance.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic            we0;
  logic [4:0]      wa0;
  logic [31:0]     wd0;
  logic [1:0][4:0] ra0;
  logic [1:0][31:0] rd0;
  logic            busy0;
  logic            drop0;

  logic            we1;
  logic [4:0]      wa1;
  logic [63:0]     wd1;
  logic [2:0][4:0] ra1;
  logic [2:0][63:0] rd1;
  logic            busy1;
  logic            drop1;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2)) dut0 (
    .clk(clk), .rst(rst), .we3(we0), .wa3(wa0), .wd3(wd0),
    .ra(ra0), .rd(rd0), .busy(busy0), .wr_drop(drop0)
  );

  regfile_mp #(.XLEN(64), .DEPTH(24), .NREAD(3)) dut1 (
    .clk(clk), .rst(rst), .we3(we1), .wa3(wa1), .wd3(wd1),
    .ra(ra1), .rd(rd1), .busy(busy1), .wr_drop(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] b0;
    logic [31:0] b1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until both instances leave CLEAR; returns edge counts (0 = never).
  task automatic count_clear(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (!busy0 && n0 == 0) n0 = n;
      if (!busy1 && n1 == 0) n1 = n;
      if (n0 != 0 && n1 != 0) break;
    end
  endtask

  initial begin
    int n0;
    int n1;
    logic [31:0] x0;
    logic [31:0] x1;

    //                we    wa     wd             ra0    ra1    e0(nb)         e1(nb)         b0(byp)        b1(byp)
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,         32'h0,         32'hDEADBEEF,  32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,         32'hDEADBEEF,  32'h0,         32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h00000055, 5'd5,  5'd7,  32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h00000055};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h00000055,  32'h00000055,  32'h00000055,  32'h00000055};
    vecs[6]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'h0,         32'h0,         32'hFFFFFFFF,  32'h0};
    vecs[7]  = '{1'b1, 5'd5,  32'h12345678, 5'd31, 5'd5,  32'hFFFFFFFF,  32'hDEADBEEF,  32'hFFFFFFFF,  32'h12345678};
    vecs[8]  = '{1'b1, 5'd1,  32'hA5A5A5A5, 5'd5,  5'd1,  32'h12345678,  32'h0,         32'h12345678,  32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 5'd1,  32'h0,        5'd1,  5'd31, 32'hA5A5A5A5,  32'hFFFFFFFF,  32'hA5A5A5A5,  32'hFFFFFFFF};
    vecs[10] = '{1'b0, 5'd9,  32'h11111111, 5'd9,  5'd9,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  32'h0,         32'h00000055,  32'h0,         32'h00000055};

    rst = 1'b1;
    we0 = 1'b0; wa0 = '0; wd0 = '0; ra0 = {5'd5, 5'd3};
    we1 = 1'b0; wa1 = '0; wd1 = '0; ra1 = {5'd1, 5'd2, 5'd3};

    // Reset held for two edges.
    repeat (2) step();
    chk("rst_busy0", 64'(busy0), 64'd1);
    chk("rst_drop0", 64'(drop0), 64'd0);
    chk("rst_rd0",   64'(rd0),   64'd0);
    chk("rst_busy1", 64'(busy1), 64'd1);

    // Clear sequence with a dropped write at clear cycle 3 on the default instance.
    rst = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 3) begin
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA;
      end
      if (n == 4) begin
        chk("drop_pulse", 64'(drop0), 64'd1);
        we0 = 1'b0; wa0 = '0; wd0 = '0;
      end
      if (n == 5) chk("drop_end", 64'(drop0), 64'd0);
      if (!busy0 && n0 == 0) n0 = n;
      if (!busy1 && n1 == 0) n1 = n;
      if (n0 != 0 && n1 != 0) break;
    end
    chk("clear_len0", 64'(n0), 64'd32);
    chk("clear_len1", 64'(n1), 64'd24);

    // Every nonzero address reads zero after clear, including the dropped-write target.
    for (int a = 1; a < 32; a++) begin
      ra0[0] = 5'(a);
      ra0[1] = 5'(32 - a);
      @(negedge clk);
      chk($sformatf("post_clear_a%0d", a), 64'(rd0), 64'd0);
      step();
    end

    // Table-driven IDLE traffic on the default instance.
    for (int k = 0; k < 12; k++) begin
      we0 = vecs[k].we; wa0 = vecs[k].wa; wd0 = vecs[k].wd;
      ra0[0] = vecs[k].ra0; ra0[1] = vecs[k].ra1;
`ifdef REGFILE_BYPASS_EN
      x0 = vecs[k].b0; x1 = vecs[k].b1;
`else
      x0 = vecs[k].e0; x1 = vecs[k].e1;
`endif
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", k),  64'(rd0[0]), 64'(x0));
      chk($sformatf("vec%0d_rd1", k),  64'(rd0[1]), 64'(x1));
      chk($sformatf("vec%0d_drop", k), 64'(drop0), 64'd0);
      step();
    end
    we0 = 1'b0;

    // Sweep instance: out-of-range write ignored, 64-bit data on all three ports.
    we1 = 1'b1; wa1 = 5'd30; wd1 = 64'hCAFEF00D_0BADBEEF;
    ra1[0] = 5'd30; ra1[1] = 5'd2; ra1[2] = 5'd23;
    @(negedge clk);
    chk("sw_wr30_cycle", 64'(rd1[0]), 64'd0);
    step();
    we1 = 1'b0;
    ra1[0] = 5'd30; ra1[1] = 5'd30; ra1[2] = 5'd30;
    @(negedge clk);
    chk("sw_rd30_p0", rd1[0], 64'd0);
    chk("sw_rd30_p2", rd1[2], 64'd0);
    chk("sw_drop", 64'(drop1), 64'd0);
    step();
    we1 = 1'b1; wa1 = 5'd23; wd1 = 64'hFEDCBA98_76543210;
    step();
    we1 = 1'b1; wa1 = 5'd1; wd1 = 64'h80000000_00000001;
    step();
    we1 = 1'b0;
    ra1[0] = 5'd23; ra1[1] = 5'd1; ra1[2] = 5'd23;
    @(negedge clk);
    chk("sw_p0_a23", rd1[0], 64'hFEDCBA98_76543210);
    chk("sw_p1_a1",  rd1[1], 64'h80000000_00000001);
    chk("sw_p2_a23", rd1[2], 64'hFEDCBA98_76543210);
    step();
    ra1[0] = 5'd1; ra1[1] = 5'd23; ra1[2] = 5'd1;
    @(negedge clk);
    chk("sw_p0_a1",  rd1[0], 64'h80000000_00000001);
    chk("sw_p1_a23", rd1[1], 64'hFEDCBA98_76543210);
    chk("sw_p2_a1",  rd1[2], 64'h80000000_00000001);
    step();
    ra1[0] = 5'd24; ra1[1] = 5'd0; ra1[2] = 5'd31;
    @(negedge clk);
    chk("sw_oob", 64'(rd1[0] | rd1[1] | rd1[2]), 64'd0);
    step();

    // Reset, then reset again mid-clear at clear cycle 10.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ra0[0] = 5'd31; ra0[1] = 5'd7;
    repeat (10) step();
    @(negedge clk);
    chk("mid_busy", 64'(busy0), 64'd1);
    chk("mid_rd_masked", 64'(rd0), 64'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 64'(busy0), 64'd1);
    rst = 1'b0;
    count_clear(n0, n1);
    chk("restart_len0", 64'(n0), 64'd32);
    chk("restart_len1", 64'(n1), 64'd24);
    ra0[0] = 5'd31; ra0[1] = 5'd5;
    ra1[0] = 5'd23; ra1[1] = 5'd1; ra1[2] = 5'd23;
    @(negedge clk);
    chk("recleared0", 64'(rd0), 64'd0);
    chk("recleared1", 64'(rd1[0] | rd1[1] | rd1[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
